// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start-bit qualification, 8 data bits LSB-first, stop check.
// Optional even-parity bit compiled in with `define UART_RX_PARITY_EN.
//
// state  | meaning
// IDLE   | waiting for a falling-edge pulse on start_edge_i
// START  | counting to mid start bit, rejecting glitches
// DATA   | sampling 8 data bits at bit centres
// PARITY | sampling the even-parity bit (UART_RX_PARITY_EN only)
// STOP   | sampling the stop bit and issuing the result strobe
module uart_rx_ctrl #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       rx_i,
    input  logic       start_edge_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       frame_err_o,
    output logic       parity_err_o,
    output logic       busy_o
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          r_state, w_state;
    logic [CW-1:0]   r_cnt,   w_cnt;
    logic [2:0]      r_idx,   w_idx;
    logic [7:0]      r_sh,    w_sh;
    logic [7:0]      r_data,  w_data;
    logic            r_valid, w_valid;
    logic            r_ferr,  w_ferr;
    logic            w_bit_done;
`ifdef UART_RX_PARITY_EN
    logic            r_perr,  w_perr;
    logic            r_perr_stb, w_perr_stb;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_sh    <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr     <= 1'b0;
            r_perr_stb <= 1'b0;
`endif
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_idx   <= w_idx;
            r_sh    <= w_sh;
            r_data  <= w_data;
            r_valid <= w_valid;
            r_ferr  <= w_ferr;
`ifdef UART_RX_PARITY_EN
            r_perr     <= w_perr;
            r_perr_stb <= w_perr_stb;
`endif
        end
    end

    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_idx      = r_idx;
        w_sh       = r_sh;
        w_data     = r_data;
        w_valid    = 1'b0;
        w_ferr     = 1'b0;
        w_bit_done = (r_cnt == FULL_M1);
`ifdef UART_RX_PARITY_EN
        w_perr     = r_perr;
        w_perr_stb = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (start_edge_i) begin
                    w_state = START;
                    w_cnt   = '0;
`ifdef UART_RX_PARITY_EN
                    w_perr  = 1'b0;
`endif
                end
            end
            START: begin
                if (r_cnt == HALF_M1) begin
                    w_cnt = '0;
                    if (!rx_i) begin
                        w_state = DATA;
                        w_idx   = '0;
                    end else begin
                        w_state = IDLE;
                    end
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            DATA: begin
                if (w_bit_done) begin
                    w_sh  = {rx_i, r_sh[7:1]};
                    w_cnt = '0;
                    w_idx = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state = PARITY;
`else
                        w_state = STOP;
`endif
                    end
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (w_bit_done) begin
                    w_cnt   = '0;
                    w_state = STOP;
                    if (rx_i != ^r_sh)
                        w_perr = 1'b1;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
`endif
            STOP: begin
                if (w_bit_done) begin
                    w_cnt   = '0;
                    w_state = IDLE;
                    // A bad stop bit outranks a parity mismatch.
                    if (!rx_i) begin
                        w_ferr = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (r_perr) begin
                        w_perr_stb = 1'b1;
`endif
                    end else begin
                        w_data  = r_sh;
                        w_valid = 1'b1;
                    end
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state = IDLE;
                w_cnt   = '0;
            end
        endcase
    end

    assign data_o      = r_data;
    assign valid_o     = r_valid;
    assign frame_err_o = r_ferr;
    assign busy_o      = (r_state != IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err_o = r_perr_stb;
`else
    assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl at CLKS_PER_BIT = 16; parity cases run when
// UART_RX_PARITY_EN is defined.
module tb_uart_rx_ctrl;

`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int CPB = 16;
    // Result strobe edge relative to the first driven edge of the start bit
    localparam int STROBE_OFS = 2 + CPB/2 + (PAR_EN ? 10 : 9) * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       start_edge = 1'b0;
    logic       rx_d = 1'b1;
    logic [7:0] data_o;
    logic       valid_o, frame_err_o, parity_err_o, busy_o;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    int         n_valid, n_ferr, n_perr;
    int         v_cyc [4];
    logic [7:0] v_dat [4];
    int         f_cyc, p_cyc, rise_cyc, fall_cyc;
    logic       busy_q = 1'b0;

    uart_rx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .rx_i         (rx),
        .start_edge_i (start_edge),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .frame_err_o  (frame_err_o),
        .parity_err_o (parity_err_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    // Edge detector model: pulse one cycle after each 1->0 on rx
    always @(posedge clk) begin
        cyc        <= cyc + 1;
        rx_d       <= rx;
        start_edge <= rx_d & ~rx;
    end

    always @(negedge clk) begin
        if (valid_o) begin
            if (n_valid < 4) begin
                v_cyc[n_valid] = cyc;
                v_dat[n_valid] = data_o;
            end
            n_valid++;
        end
        if (frame_err_o) begin
            f_cyc = cyc;
            n_ferr++;
        end
        if (parity_err_o) begin
            p_cyc = cyc;
            n_perr++;
        end
        if (busy_o && !busy_q) rise_cyc = cyc;
        if (!busy_o && busy_q) fall_cyc = cyc;
        busy_q = busy_o;
    end

    task automatic clear_mon();
        n_valid  = 0;
        n_ferr   = 0;
        n_perr   = 0;
        f_cyc    = -1;
        p_cyc    = -1;
        rise_cyc = -1;
        fall_cyc = -1;
        for (int i = 0; i < 4; i++) begin
            v_cyc[i] = -1;
            v_dat[i] = 8'hxx;
        end
    endtask

    // b returns the edge after which the start bit is driven low
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, output int b);
        @(posedge clk); #1;
        b  = cyc;
        rx = 1'b0;
        repeat (CPB-1) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            rx = d[i];
            repeat (CPB-1) @(posedge clk);
        end
        if (PAR_EN) begin
            @(posedge clk); #1;
            rx = par;
            repeat (CPB-1) @(posedge clk);
        end
        @(posedge clk); #1;
        rx = stop;
        repeat (CPB-1) @(posedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
        checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", frame_err_o); end
        checks++; if (parity_err_o !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b expected 0", parity_err_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_frame_a5();
        int b;
        clear_mon();
        send_frame(8'hA5, 1'b0, 1'b1, b);
        repeat (8) @(posedge clk);
        checks++; if (n_valid !== 1) begin errors++; $display("FAIL a5_valid_count: got %0d expected 1", n_valid); end
        checks++; if (v_cyc[0] !== b + STROBE_OFS) begin errors++; $display("FAIL a5_valid_time: got %0d expected %0d", v_cyc[0], b + STROBE_OFS); end
        checks++; if (v_dat[0] !== 8'hA5) begin errors++; $display("FAIL a5_data: got %h expected a5", v_dat[0]); end
        checks++; if (n_ferr !== 0) begin errors++; $display("FAIL a5_ferr: got %0d expected 0", n_ferr); end
        checks++; if (rise_cyc !== b + 2) begin errors++; $display("FAIL a5_busy_rise: got %0d expected %0d", rise_cyc, b + 2); end
        checks++; if (fall_cyc !== b + STROBE_OFS) begin errors++; $display("FAIL a5_busy_fall: got %0d expected %0d", fall_cyc, b + STROBE_OFS); end
        checks++; if (data_o !== 8'hA5) begin errors++; $display("FAIL a5_data_hold: got %h expected a5", data_o); end
    endtask

    task automatic test_glitch();
        int b;
        clear_mon();
        @(posedge clk); #1;
        b  = cyc;
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (40) @(posedge clk);
        checks++; if (fall_cyc !== b + 2 + CPB/2) begin errors++; $display("FAIL glitch_idle_time: got %0d expected %0d", fall_cyc, b + 2 + CPB/2); end
        checks++; if (n_valid !== 0) begin errors++; $display("FAIL glitch_valid: got %0d expected 0", n_valid); end
        checks++; if (n_ferr !== 0) begin errors++; $display("FAIL glitch_ferr: got %0d expected 0", n_ferr); end
        checks++; if (data_o !== 8'hA5) begin errors++; $display("FAIL glitch_data: got %h expected a5", data_o); end
    endtask

    task automatic test_frame_err();
        int b;
        clear_mon();
        send_frame(8'h3C, 1'b0, 1'b0, b);
        @(posedge clk); #1;
        rx = 1'b1;
        repeat (8) @(posedge clk);
        checks++; if (n_ferr !== 1) begin errors++; $display("FAIL ferr_count: got %0d expected 1", n_ferr); end
        checks++; if (f_cyc !== b + STROBE_OFS) begin errors++; $display("FAIL ferr_time: got %0d expected %0d", f_cyc, b + STROBE_OFS); end
        checks++; if (n_valid !== 0) begin errors++; $display("FAIL ferr_valid: got %0d expected 0", n_valid); end
        checks++; if (data_o !== 8'hA5) begin errors++; $display("FAIL ferr_data: got %h expected a5", data_o); end
    endtask

    task automatic test_back_to_back();
        int b0, b1;
        clear_mon();
        send_frame(8'h00, 1'b0, 1'b1, b0);
        send_frame(8'hFF, 1'b0, 1'b1, b1);
        repeat (8) @(posedge clk);
        checks++; if (n_valid !== 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", n_valid); end
        checks++; if (v_dat[0] !== 8'h00) begin errors++; $display("FAIL b2b_data0: got %h expected 00", v_dat[0]); end
        checks++; if (v_dat[1] !== 8'hFF) begin errors++; $display("FAIL b2b_data1: got %h expected ff", v_dat[1]); end
        checks++; if (v_cyc[0] !== b0 + STROBE_OFS) begin errors++; $display("FAIL b2b_time0: got %0d expected %0d", v_cyc[0], b0 + STROBE_OFS); end
        checks++; if (v_cyc[1] - v_cyc[0] !== (PAR_EN ? 11 : 10) * CPB) begin errors++; $display("FAIL b2b_spacing: got %0d expected %0d", v_cyc[1] - v_cyc[0], (PAR_EN ? 11 : 10) * CPB); end
        checks++; if (n_ferr !== 0) begin errors++; $display("FAIL b2b_ferr: got %0d expected 0", n_ferr); end
    endtask

    task automatic test_mid_reset();
        int b;
        clear_mon();
        fork
            send_frame(8'hC3, 1'b0, 1'b1, b);
            begin
                repeat (73) @(posedge clk);
                #1;
                checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL mrst_busy_before: got %b expected 1", busy_o); end
                rst_n = 1'b0;
                #1;
                checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL mrst_data: got %h expected 00", data_o); end
                checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL mrst_busy: got %b expected 0", busy_o); end
                checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL mrst_valid: got %b expected 0", valid_o); end
            end
        join
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        checks++; if (n_valid !== 0) begin errors++; $display("FAIL mrst_no_valid: got %0d expected 0", n_valid); end
        clear_mon();
        send_frame(8'h5A, 1'b0, 1'b1, b);
        repeat (8) @(posedge clk);
        checks++; if (n_valid !== 1) begin errors++; $display("FAIL mrst_5a_count: got %0d expected 1", n_valid); end
        checks++; if (v_dat[0] !== 8'h5A) begin errors++; $display("FAIL mrst_5a_data: got %h expected 5a", v_dat[0]); end
        checks++; if (v_cyc[0] !== b + STROBE_OFS) begin errors++; $display("FAIL mrst_5a_time: got %0d expected %0d", v_cyc[0], b + STROBE_OFS); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int b;
        clear_mon();
        send_frame(8'h81, 1'b0, 1'b1, b);
        repeat (8) @(posedge clk);
        checks++; if (n_valid !== 1) begin errors++; $display("FAIL par_ok_count: got %0d expected 1", n_valid); end
        checks++; if (v_cyc[0] !== b + 2 + 168) begin errors++; $display("FAIL par_ok_time: got %0d expected %0d", v_cyc[0], b + 170); end
        checks++; if (v_dat[0] !== 8'h81) begin errors++; $display("FAIL par_ok_data: got %h expected 81", v_dat[0]); end
        checks++; if (n_perr !== 0) begin errors++; $display("FAIL par_ok_perr: got %0d expected 0", n_perr); end
        clear_mon();
        send_frame(8'h81, 1'b1, 1'b1, b);
        repeat (8) @(posedge clk);
        checks++; if (n_perr !== 1) begin errors++; $display("FAIL par_bad_count: got %0d expected 1", n_perr); end
        checks++; if (p_cyc !== b + 2 + 168) begin errors++; $display("FAIL par_bad_time: got %0d expected %0d", p_cyc, b + 170); end
        checks++; if (n_valid !== 0) begin errors++; $display("FAIL par_bad_valid: got %0d expected 0", n_valid); end
        clear_mon();
        send_frame(8'h81, 1'b1, 1'b0, b);
        @(posedge clk); #1;
        rx = 1'b1;
        repeat (8) @(posedge clk);
        checks++; if (n_ferr !== 1 || n_perr !== 0) begin errors++; $display("FAIL par_ferr_priority: got ferr=%0d perr=%0d expected ferr=1 perr=0", n_ferr, n_perr); end
        checks++; if (data_o !== 8'h81) begin errors++; $display("FAIL par_data_hold: got %h expected 81", data_o); end
    endtask
`endif

    initial begin
        clear_mon();
        test_reset();
        test_frame_a5();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_mid_reset();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

UART receive controller that sequences the falling-edge detector on the RX line. It waits for a falling-edge pulse from the edge detector in `IDLE` and qualifies the start bit at mid-bit. It then samples 8 data bits LSB-first at the bit centres, checks the stop bit, and presents one byte per frame with a single-cycle strobe. It sits between the synchronized RX pin and edge detector on one side and the byte consumer (FIFO or command parser) on the other.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434: clock cycles per bit (50 MHz / 115200). Legal range is ≥ 4. `HALF = CLKS_PER_BIT/2`, integer division.

Ports:
- `clk_i`  in  1  system clock; all logic is on the rising edge.
- `rst_n_i`  in  1  asynchronous, active-low reset.
- `rx_i`  in  1  synchronized RX line level; idle level is 1.
- `start_edge_i`  in  1  one-cycle falling-edge pulse from the edge detector's `negedge_o`.
- `data_o`  out  8  last good byte. Held until the next good frame.
- `valid_o`  out  1  one-cycle strobe when `data_o` is updated.
- `frame_err_o`  out  1  one-cycle strobe when the stop bit is sampled as 0.
- `parity_err_o`  out  1  one-cycle strobe on parity mismatch. Constant 0 unless `UART_RX_PARITY_EN` is defined.
- `busy_o`  out  1  high whenever the state is not `IDLE`.

## Operation
- The state machine has five states: `IDLE`, `START`, `DATA`, `PARITY` (present only with the macro), and `STOP`.
- Bit counter `cnt` is `$clog2(CLKS_PER_BIT)` bits wide. Bit index `idx` is 3 bits. There is an 8-bit shift register `sh`.
- `IDLE`: when `start_edge_i` = 1, go to `START` with `cnt` = 0. All other inputs are ignored.
- `START`: `cnt` increments each cycle. When `cnt` = `HALF`-1, sample `rx_i`:
  - 0: go to `DATA` with `cnt` = 0 and `idx` = 0.
  - 1: false start; go to `IDLE`. No strobes are raised.
- `DATA`: when `cnt` = `CLKS_PER_BIT`-1, do `sh <= {rx_i, sh[7:1]}`, set `cnt` = 0 and increment `idx`. On the sample where `idx` = 7, go to `PARITY` if the macro is defined, otherwise to `STOP`.
- `PARITY`: at the full-bit count, compare `rx_i` with `^sh` (even parity). Mismatch sets a sticky `perr` flag. Go to `STOP`.
- `STOP`: at the full-bit count, sample `rx_i` and go to `IDLE`:
  - 1 and no `perr`: `data_o <= sh`, `valid_o <= 1`.
  - 1 and `perr`: `parity_err_o <= 1`. `data_o` is unchanged.
  - 0: `frame_err_o <= 1`. `data_o` is unchanged. `frame_err_o` takes priority over `parity_err_o`.
- `start_edge_i` pulses outside `IDLE` are ignored. This covers edges from data bits and the edge arriving in the same cycle `STOP` exits.
- Reset mid-frame: the state returns to `IDLE` immediately and the partial byte is discarded.

## Timing
- Values at reset: `data_o` = 0x00, `valid_o` = 0, `frame_err_o` = 0, `parity_err_o` = 0, `busy_o` = 0. `cnt`, `idx`, `sh` and `perr` are also cleared.
- E0 is the rising edge that samples `start_edge_i` = 1 in `IDLE`. `busy_o` is high from after E0.
- Start-bit sample is at E0+`HALF`. Data bit k (k = 1..8) is sampled at E0+`HALF`+k·`CLKS_PER_BIT`.
- Without the macro, the stop bit is sampled at E0+`HALF`+9·`CLKS_PER_BIT`. The strobe is high, and `busy_o` is low, for exactly the cycle after that edge.
- With the macro, parity is sampled at +9·`CLKS_PER_BIT` and the stop bit at +10·`CLKS_PER_BIT`.
- All outputs are registered. There is no combinational path from inputs to outputs.
- The input `rx_i` must already be synchronized. The block adds no synchronizer.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - the `PARITY` state is compiled in;
  - frames are 1 start + 8 data + 1 even-parity + 1 stop bit;
  - `parity_err_o` is live.
- Not defined:
  - frames are 8N1;
  - no parity logic is built;
  - `parity_err_o` is tied to 0.

## Test plan
All scenarios use `CLKS_PER_BIT` = 16 and drive `rx_i` bit-accurately, with `start_edge_i` pulsed one cycle after the falling edge.
- Frame 0xA5, 8N1 → `valid_o` is a one-cycle pulse at E0+152 with `data_o` = 0xA5; `frame_err_o` = 0; `busy_o` falls in the same cycle.
- Glitch on `rx_i`, low for 4 cycles then 1 → state returns to `IDLE` at E0+8; no strobes; `data_o` keeps its previous value.
- Frame 0x3C with stop bit 0 → `frame_err_o` pulses at E0+152; `valid_o` = 0; `data_o` is unchanged.
- Back-to-back frames 0x00 then 0xFF with no idle gap → two `valid_o` pulses, 160 cycles apart, with values 0x00 then 0xFF. Falling edges inside the data bits cause no restart.
- `rst_n_i` low at E0+70 during a frame → outputs are 0 immediately. After release, a new frame 0x5A is received correctly.
- With `UART_RX_PARITY_EN`:
  - 0x81 with parity bit 0 → `valid_o` at E0+168.
  - The same frame with parity bit 1 → `parity_err_o` pulse at E0+168 and no `valid_o`.
